// File: rtl/sfifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_pkg
//  Description : Shared helpers for the single-clock FIFO family.
//                - clog2      : address width for a given storage depth
//                               (SIZE_DEPTH = 2**SIZE_ADDR)
//                - ptr_width  : width of a wrap-bit pointer (SIZE_ADDR + 1).
//                               Users declare their pointer type as
//                               `typedef logic [ptr_width(SIZE_ADDR)-1:0] ptr_t`.
//  Revision    : 1.0  initial release
// ============================================================================
package sfifo_pkg;

   // Ceiling log2, valid for value >= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // Pointers carry one extra MSB so that full and empty can be told apart
   // when the address bits match.
   function automatic int ptr_width(input int size_addr);
      return size_addr + 1;
   endfunction

endpackage : sfifo_pkg
`default_nettype wire

// File: rtl/sfifo_mem_2p.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_mem_2p
//  Description : Single-clock two-port register array. Synchronous write
//                port and a registered read port. The storage array itself
//                is never reset; only the read data register is.
//  Ports       : i_clk      clock, rising edge
//                i_rst      synchronous active-high reset (read register only)
//                i_wr_en    write strobe
//                i_wr_addr  write address
//                i_wr_data  write data
//                i_rd_en    read strobe; loads o_rd_data on the edge
//                i_rd_addr  read address
//                o_rd_data  registered read data, held while i_rd_en is low
//  Revision    : 1.0  initial release
// ============================================================================
module sfifo_mem_2p
   import sfifo_pkg::*;
#(
   parameter int SIZE_DATA  = 8,
   parameter int SIZE_DEPTH = 16,
   localparam int C_ADDR_W  = clog2(SIZE_DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wr_en,
   input  logic [C_ADDR_W-1:0]  i_wr_addr,
   input  logic [SIZE_DATA-1:0] i_wr_data,
   input  logic                 i_rd_en,
   input  logic [C_ADDR_W-1:0]  i_rd_addr,
   output logic [SIZE_DATA-1:0] o_rd_data
);

   logic [SIZE_DATA-1:0] r_mem [SIZE_DEPTH];
   logic [SIZE_DATA-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // A read and a write to the same address on one edge return the old
   // word; the FIFO relies on this when it pushes and pops while full.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule : sfifo_mem_2p
`default_nettype wire

// File: rtl/sfifo_single_clk.sv
`default_nettype none
// ============================================================================
//  Module      : sfifo_single_clk
//  Description : Parametrised synchronous FIFO with occupancy count,
//                full/empty/almost flags, sticky overflow/underflow errors
//                and synchronous flush.
//                Optional macro SFIFO_FWFT_EN selects first-word-fall-through:
//                the head word is prefetched into o_data and i_rd_en acts as
//                an acknowledge. Without the macro, reads have one cycle of
//                latency (standard mode).
//  Ports       : i_clk           clock, rising edge
//                i_rst           synchronous reset, active-high
//                i_flush         synchronous flush (empties FIFO)
//                i_clr_err       clears sticky error flags
//                i_wr_en/i_data  write request and data
//                i_rd_en         read request (acknowledge in FWFT mode)
//                o_data          registered read data
//                o_rd_valid      o_data holds a newly popped / head word
//                o_full/o_empty  occupancy == SIZE_DEPTH / == 0
//                o_almost_full   occupancy >= AFULL_TH
//                o_almost_empty  occupancy <= AEMPTY_TH
//                o_count         occupancy 0..SIZE_DEPTH
//                o_overflow      sticky: write rejected
//                o_underflow     sticky: read while empty
//  Revision    : 1.0  initial release
// ============================================================================
module sfifo_single_clk
   import sfifo_pkg::*;
#(
   parameter int SIZE_DATA  = 8,
   parameter int SIZE_ADDR  = 4,
   parameter int SIZE_DEPTH = 16,
   parameter int AFULL_TH   = 12,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_clr_err,
   input  logic                 i_wr_en,
   input  logic [SIZE_DATA-1:0] i_data,
   input  logic                 i_rd_en,
   output logic [SIZE_DATA-1:0] o_data,
   output logic                 o_rd_valid,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_almost_full,
   output logic                 o_almost_empty,
   output logic [SIZE_ADDR:0]   o_count,
   output logic                 o_overflow,
   output logic                 o_underflow
);

   localparam int C_PTR_W = ptr_width(SIZE_ADDR);
   typedef logic [C_PTR_W-1:0] ptr_t;

   localparam logic [SIZE_ADDR:0] c_afull_th  = AFULL_TH[SIZE_ADDR:0];
   localparam logic [SIZE_ADDR:0] c_aempty_th = AEMPTY_TH[SIZE_ADDR:0];

   ptr_t r_wr_ptr;
   ptr_t r_rd_ptr;
   logic r_rd_valid;
   logic r_overflow;
   logic r_underflow;

   logic [SIZE_ADDR:0]   w_mem_count;
   logic                 w_mem_empty;
   logic                 w_wr_req;
   logic                 w_rd_req;
   logic [SIZE_ADDR:0]   w_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_mem_pop;
   logic                 w_rd_valid_nxt;
   logic                 w_ovf_set;
   logic                 w_unf_set;

   // Occupancy of the storage array, modulo 2**(SIZE_ADDR+1).
   assign w_mem_count = r_wr_ptr - r_rd_ptr;
   assign w_mem_empty = (r_wr_ptr == r_rd_ptr);

   // A flush cycle swallows any request, so nothing downstream (pointer
   // moves, error flags) can see it.
   assign w_wr_req = i_wr_en & ~i_flush;
   assign w_rd_req = i_rd_en & ~i_flush;

`ifdef SFIFO_FWFT_EN
   localparam logic [SIZE_ADDR:0] c_depth = SIZE_DEPTH[SIZE_ADDR:0];

   logic w_ack;

   // The prefetched word in o_data counts as stored; total capacity stays
   // SIZE_DEPTH, so the array never holds more than SIZE_DEPTH words.
   assign w_ack     = w_rd_req & r_rd_valid;
   assign w_count   = w_mem_count + {{SIZE_ADDR{1'b0}}, r_rd_valid};
   assign w_full    = (w_count == c_depth);
   assign w_empty   = ~r_rd_valid;
   assign w_push    = w_wr_req & (~w_full | w_ack);
   // Refill the output stage whenever it is idle or being consumed.
   assign w_mem_pop = ~i_flush & ~w_mem_empty & (~r_rd_valid | w_ack);
   assign w_rd_valid_nxt = w_mem_pop | (r_rd_valid & ~w_ack);
   assign w_ovf_set = w_wr_req & ~w_push;
   assign w_unf_set = w_rd_req & ~r_rd_valid;
`else
   logic w_mem_full;

   assign w_mem_full = (r_wr_ptr[SIZE_ADDR-1:0] == r_rd_ptr[SIZE_ADDR-1:0]) &&
                       (r_wr_ptr[SIZE_ADDR] != r_rd_ptr[SIZE_ADDR]);

   assign w_count   = w_mem_count;
   assign w_full    = w_mem_full;
   assign w_empty   = w_mem_empty;
   assign w_mem_pop = w_rd_req & ~w_mem_empty;
   // A pop frees a slot on the same edge, so a full FIFO still accepts a
   // push that coincides with a pop.
   assign w_push    = w_wr_req & (~w_full | w_mem_pop);
   assign w_rd_valid_nxt = w_mem_pop;
   assign w_ovf_set = w_wr_req & ~w_push;
   assign w_unf_set = w_rd_req & w_mem_empty;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_valid <= w_rd_valid_nxt;
         end
         // Setting wins over a clear arriving in the same cycle.
         r_overflow  <= w_ovf_set | (r_overflow  & ~i_clr_err);
         r_underflow <= w_unf_set | (r_underflow & ~i_clr_err);
      end
   end

   sfifo_mem_2p #(
      .SIZE_DATA  (SIZE_DATA),
      .SIZE_DEPTH (SIZE_DEPTH)
   ) u_mem (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[SIZE_ADDR-1:0]),
      .i_wr_data (i_data),
      .i_rd_en   (w_mem_pop),
      .i_rd_addr (r_rd_ptr[SIZE_ADDR-1:0]),
      .o_rd_data (o_data)
   );

   assign o_rd_valid     = r_rd_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (w_count >= c_afull_th);
   assign o_almost_empty = (w_count <= c_aempty_th);
   assign o_count        = w_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule : sfifo_single_clk
`default_nettype wire

// File: tb/tb_sfifo_single_clk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfifo_single_clk
//  Description : Self-checking bench for sfifo_single_clk (standard mode).
//                A queue-based reference model tracks the stored words,
//                read data and sticky error flags; directed sequences are
//                followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sfifo_single_clk;

   localparam int C_DW     = 8;
   localparam int C_AW     = 4;
   localparam int C_DEPTH  = 16;
   localparam int C_AFULL  = 12;
   localparam int C_AEMPTY = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            r_rst     = 1'b1;
   logic            r_flush   = 1'b0;
   logic            r_clr_err = 1'b0;
   logic            r_wr_en   = 1'b0;
   logic            r_rd_en   = 1'b0;
   logic [C_DW-1:0] r_data    = '0;

   logic [C_DW-1:0] w_data;
   logic            w_rd_valid;
   logic            w_full;
   logic            w_empty;
   logic            w_almost_full;
   logic            w_almost_empty;
   logic [C_AW:0]   w_count;
   logic            w_overflow;
   logic            w_underflow;

   sfifo_single_clk #(
      .SIZE_DATA  (C_DW),
      .SIZE_ADDR  (C_AW),
      .SIZE_DEPTH (C_DEPTH),
      .AFULL_TH   (C_AFULL),
      .AEMPTY_TH  (C_AEMPTY)
   ) dut (
      .i_clk          (clk),
      .i_rst          (r_rst),
      .i_flush        (r_flush),
      .i_clr_err      (r_clr_err),
      .i_wr_en        (r_wr_en),
      .i_data         (r_data),
      .i_rd_en        (r_rd_en),
      .o_data         (w_data),
      .o_rd_valid     (w_rd_valid),
      .o_full         (w_full),
      .o_empty        (w_empty),
      .o_almost_full  (w_almost_full),
      .o_almost_empty (w_almost_empty),
      .o_count        (w_count),
      .o_overflow     (w_overflow),
      .o_underflow    (w_underflow)
   );

   // Reference model state
   logic [C_DW-1:0] m_q[$];
   logic [C_DW-1:0] m_data  = '0;
   bit              m_valid = 1'b0;
   bit              m_ovf   = 1'b0;
   bit              m_unf   = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, n_cyc, act, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int cnt;
      bit pop_ok;
      bit push_ok;
      bit set_o;
      bit set_u;
      if (r_rst) begin
         m_q.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else if (r_flush) begin
         m_q.delete();
         m_valid = 1'b0;
         if (r_clr_err) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
      end else begin
         cnt     = m_q.size();
         pop_ok  = r_rd_en && (cnt > 0);
         push_ok = r_wr_en && ((cnt < C_DEPTH) || pop_ok);
         set_o   = r_wr_en && !push_ok;
         set_u   = r_rd_en && (cnt == 0);
         m_valid = pop_ok;
         if (pop_ok) m_data = m_q.pop_front();
         if (push_ok) m_q.push_back(r_data);
         m_ovf = set_o || (m_ovf && !r_clr_err);
         m_unf = set_u || (m_unf && !r_clr_err);
      end
   endtask

   task automatic check_all();
      int cnt;
      cnt = m_q.size();
      check_eq("o_data",         32'(w_data),         32'(m_data));
      check_eq("o_rd_valid",     32'(w_rd_valid),     32'(m_valid));
      check_eq("o_count",        32'(w_count),        cnt);
      check_eq("o_full",         32'(w_full),         32'(cnt == C_DEPTH));
      check_eq("o_empty",        32'(w_empty),        32'(cnt == 0));
      check_eq("o_almost_full",  32'(w_almost_full),  32'(cnt >= C_AFULL));
      check_eq("o_almost_empty", 32'(w_almost_empty), 32'(cnt <= C_AEMPTY));
      check_eq("o_overflow",     32'(w_overflow),     32'(m_ovf));
      check_eq("o_underflow",    32'(w_underflow),    32'(m_unf));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare.
   task automatic cycle(input bit rst, input bit flush, input bit clr,
                        input bit wr, input logic [C_DW-1:0] din, input bit rd);
      r_rst     = rst;
      r_flush   = flush;
      r_clr_err = clr;
      r_wr_en   = wr;
      r_data    = din;
      r_rd_en   = rd;
      model_step();
      @(posedge clk);
      #1;
      n_cyc++;
      check_all();
   endtask

   initial begin
      int wr_bias;
      int rd_bias;

      // Reset state
      cycle(1, 0, 0, 0, 8'h00, 0);
      check_eq("rst_empty", 32'(w_empty), 32'd1);
      check_eq("rst_aempty", 32'(w_almost_empty), 32'd1);

      // Fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, C_DW'(i), 0);
      check_eq("fill_full", 32'(w_full), 32'd1);
      check_eq("fill_count", 32'(w_count), 32'd16);

      // 17th write rejected
      cycle(0, 0, 0, 1, 8'hAA, 0);
      check_eq("ovf_17th", 32'(w_overflow), 32'd1);

      // Drain: order must be 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 0, 0, 8'h00, 1);
         check_eq("rd_seq", 32'(w_data), i);
      end
      cycle(0, 0, 0, 0, 8'h00, 1);
      check_eq("unf_17th", 32'(w_underflow), 32'd1);
      check_eq("hold_data", 32'(w_data), 32'h0F);

      // Clear errors
      cycle(0, 0, 1, 0, 8'h00, 0);

      // Pointer wrap at constant occupancy 5
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, C_DW'(8'h10 + i), 0);
      for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, C_DW'(8'h20 + i), 1);
      check_eq("wrap_count", 32'(w_count), 32'd5);

      // Fill to full, then push+pop while full
      for (int i = 0; i < 11; i++) cycle(0, 0, 0, 1, C_DW'(8'h80 + i), 0);
      cycle(0, 0, 0, 1, 8'h55, 1);
      check_eq("full_rw_count", 32'(w_count), 32'd16);
      check_eq("full_rw_ovf", 32'(w_overflow), 32'd0);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 8'h00, 1);
      check_eq("full_rw_last", 32'(w_data), 32'h55);

      // Push+pop while empty
      cycle(0, 0, 0, 1, 8'h66, 1);
      check_eq("empty_rw_unf", 32'(w_underflow), 32'd1);
      check_eq("empty_rw_count", 32'(w_count), 32'd1);
      cycle(0, 0, 0, 0, 8'h00, 1);

      // Flush with 7 words stored, errors retained
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, C_DW'(8'hC0 + i), 0);
      cycle(0, 1, 0, 1, 8'h99, 1);
      check_eq("flush_count", 32'(w_count), 32'd0);
      check_eq("flush_unf_kept", 32'(w_underflow), 32'd1);

      // Reset together with a write
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, C_DW'(8'hD0 + i), 0);
      cycle(1, 0, 0, 1, 8'h77, 0);
      check_eq("rst_wr_count", 32'(w_count), 32'd0);
      check_eq("rst_wr_unf", 32'(w_underflow), 32'd0);

      // Randomized traffic with drifting read/write pressure
      wr_bias = 50;
      rd_bias = 50;
      for (int i = 0; i < 800; i++) begin
         if (i % 50 == 0) begin
            wr_bias = $urandom_range(90, 10);
            rd_bias = $urandom_range(90, 10);
         end
         cycle(($urandom % 250) == 0,
               ($urandom % 60) == 0,
               ($urandom % 20) == 0,
               ($urandom % 100) < wr_bias,
               C_DW'($urandom),
               ($urandom % 100) < rd_bias);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", n_cyc);
      $fatal(1);
   end

endmodule : tb_sfifo_single_clk
`default_nettype wire
